// File: rtl/prog_loader_ctrl.sv
// Bit-serial program loader and run sequencer for the one-bit NAND processor core.
// Optional run watchdog with `timeout` output: define PROG_LOADER_WATCHDOG_EN.
module prog_loader_ctrl #(
    parameter int INSTRUCTION_LENGTH  = 13,
    parameter int PROG_COUNTER_LENGTH = 10,
    parameter int INSTRUCTION_MEM     = 1000,
    parameter int NUM_OUT_REGS        = 7
`ifdef PROG_LOADER_WATCHDOG_EN
    ,
    parameter int RUN_LIMIT           = 1024
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [PROG_COUNTER_LENGTH-1:0] prog_len,
    input  logic [INSTRUCTION_LENGTH-1:0]  word_data,
    input  logic                           word_valid,
    output logic                           word_ready,
    input  logic                           stop,
    input  logic [1:0]                     run_in,
    output logic                           proc_reset,
    output logic                           proc_en,
    output logic [1:0]                     proc_in,
    input  logic [NUM_OUT_REGS-1:0]        proc_out,
    output logic [NUM_OUT_REGS-1:0]        result,
    output logic                           busy,
    output logic                           running,
    output logic                           done,
    output logic                           error
`ifdef PROG_LOADER_WATCHDOG_EN
    ,
    output logic                           timeout
`endif
);

    localparam int BW = (INSTRUCTION_LENGTH > 1) ? $clog2(INSTRUCTION_LENGTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(INSTRUCTION_LENGTH - 1);
    localparam logic [PROG_COUNTER_LENGTH-1:0] MAX_LEN = PROG_COUNTER_LENGTH'(INSTRUCTION_MEM);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_RUN, S_STOP, S_ERROR} state_t;

    state_t                           state_q, state_d;
    logic [INSTRUCTION_LENGTH-1:0]    shreg_q, shreg_d;
    logic [BW-1:0]                    bit_cnt_q, bit_cnt_d;
    logic [PROG_COUNTER_LENGTH-1:0]   words_left_q, words_left_d;
    logic [NUM_OUT_REGS-1:0]          result_q, result_d;
    logic                             proc_reset_q, proc_en_q, busy_q, running_q, done_q, error_q;
    logic                             xfer, len_ok, wd_fire;

`ifdef PROG_LOADER_WATCHDOG_EN
    localparam logic [15:0] RUN_LAST = 16'(RUN_LIMIT - 1);
    logic [15:0] run_cnt_q, run_cnt_d;
    logic        timeout_q, timeout_d;
    assign wd_fire = (run_cnt_q == RUN_LAST);
    assign timeout = timeout_q;
`else
    assign wd_fire = 1'b0;
`endif

    // A new word is accepted in FETCH and on the last bit of a word while words remain,
    // so consecutive words stream into the core without a bubble.
    assign word_ready = (state_q == S_FETCH) ||
                        (state_q == S_SHIFT && bit_cnt_q == LAST_BIT && words_left_q != '0);
    assign xfer       = word_valid && word_ready;
    assign len_ok     = (prog_len != '0) && (prog_len <= MAX_LEN);

    assign proc_in    = running_q ? run_in : (proc_en_q ? {1'b0, shreg_q[0]} : 2'b00);
    assign proc_reset = proc_reset_q;
    assign proc_en    = proc_en_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign running    = running_q;
    assign done       = done_q;
    assign error      = error_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        words_left_d = words_left_q;
        result_d     = result_q;
`ifdef PROG_LOADER_WATCHDOG_EN
        run_cnt_d    = run_cnt_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    if (len_ok) begin
                        words_left_d = prog_len;
                        state_d      = S_FETCH;
`ifdef PROG_LOADER_WATCHDOG_EN
                        timeout_d    = 1'b0;
`endif
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_FETCH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    shreg_d      = word_data;
                    bit_cnt_d    = '0;
                    words_left_d = words_left_q - 1'b1;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (bit_cnt_q == LAST_BIT) begin
                    if (words_left_q != '0) begin
                        // The core writes on every en-high cycle, so a late word is fatal.
                        if (xfer) begin
                            shreg_d      = word_data;
                            bit_cnt_d    = '0;
                            words_left_d = words_left_q - 1'b1;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end else begin
                        state_d = S_RUN;
`ifdef PROG_LOADER_WATCHDOG_EN
                        run_cnt_d = '0;
`endif
                    end
                end else begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
`ifdef PROG_LOADER_WATCHDOG_EN
                run_cnt_d = run_cnt_q + 1'b1;
                if (wd_fire) timeout_d = 1'b1;
`endif
                if (stop || wd_fire) begin
                    result_d = proc_out;
                    state_d  = S_STOP;
                end
            end
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            result_q     <= '0;
            proc_reset_q <= 1'b1;
            proc_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef PROG_LOADER_WATCHDOG_EN
            run_cnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            result_q     <= result_d;
            proc_reset_q <= (state_d == S_IDLE) || (state_d == S_ERROR);
            proc_en_q    <= (state_d == S_SHIFT);
            busy_q       <= (state_d == S_FETCH) || (state_d == S_SHIFT) || (state_d == S_RUN);
            running_q    <= (state_d == S_RUN);
            done_q       <= (state_d == S_STOP);
            error_q      <= (state_d == S_ERROR);
`ifdef PROG_LOADER_WATCHDOG_EN
            run_cnt_q    <= run_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

endmodule

// File: doc/prog_loader_ctrl.md
Name: prog_loader_ctrl

Overview:
Sequencer for the one-bit NAND processor. It holds the processor in reset while idle, then streams a host-supplied program into instruction memory bit-serially through the processor's `en`/`inReg[0]` load path. It then releases the core to run with user inputs muxed onto `inReg`, and on stop it snapshots `outReg` into a result register before re-resetting the core. It sits between the host/program source and the processor's `reset`, `en`, `inReg` and `outReg` pins.

Parameters:
INSTRUCTION_LENGTH, 13, bits per instruction word (bits shifted per word)
PROG_COUNTER_LENGTH, 10, width of prog_len and the word counter
INSTRUCTION_MEM, 1000, maximum legal prog_len
NUM_OUT_REGS, 7, width of proc_out/result
RUN_LIMIT, 1024, watchdog run-cycle limit (used only with the macro; counter is 16 bits)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle request to begin a load; sampled in IDLE/ERROR only
prog_len  in  PROG_COUNTER_LENGTH  number of words to load, sampled with start
word_data  in  INSTRUCTION_LENGTH  instruction word, bit 0 shifted first
word_valid  in  1  word_data valid
word_ready  out  1  block accepts word_data this cycle (transfer = valid & ready)
stop  in  1  one-cycle request to end RUN (or abort LOAD)
run_in  in  2  user inputs forwarded to the core during RUN
proc_reset  out  1  to core reset (active-high, synchronous at core)
proc_en  out  1  to core en
proc_in  out  2  to core inReg
proc_out  in  NUM_OUT_REGS  from core outReg
result  out  NUM_OUT_REGS  snapshot of proc_out taken at stop
busy  out  1  high in FETCH/SHIFT/RUN
running  out  1  high in RUN
done  out  1  one-cycle pulse when STOP snapshot completes
error  out  1  sticky error flag

Behaviour:
- Reset values: state=IDLE, proc_reset=1, proc_en=0, proc_in=0, word_ready=0, result=0, busy=0, running=0, done=0, error=0, all counters 0.
- Reset is asynchronous. Asserting it mid-load or mid-run returns to IDLE immediately, and the core is re-cleared via proc_reset=1.
- IDLE: proc_reset=1, proc_en=0, proc_in=0.
  - start with 1 <= prog_len <= INSTRUCTION_MEM: latch words_left=prog_len, go to FETCH.
  - start with prog_len=0 or prog_len > INSTRUCTION_MEM: go to ERROR.
- FETCH (first word only): proc_reset=0, proc_en=0, word_ready=1.
  - On transfer: shreg <= word_data, bit_cnt=0, words_left decrements, go to SHIFT.
  - Waits indefinitely for the word.
- SHIFT: proc_en=1, proc_in={1'b0, shreg[0]}. Each cycle shreg shifts right and bit_cnt increments.
  - proc_en rises exactly once per load session, so the core's load counters clear once. proc_en stays high for exactly 13*prog_len consecutive cycles.
  - When bit_cnt==12 and words_left>0: word_ready=1.
    - Transfer: reload shreg, bit_cnt=0, stay in SHIFT with no bubble.
    - No word_valid: go to ERROR (underflow). The core cannot stall because it writes every en-high cycle.
  - When bit_cnt==12 and words_left==0: go to RUN. proc_en=0 in the next cycle.
- RUN: proc_reset=0, proc_en=0, proc_in=run_in (combinational pass-through), running=1.
  - stop: go to STOP.
- STOP: one cycle. result <= proc_out, done=1, proc_en=0, proc_in=0, then go to IDLE.
- ERROR: error=1, proc_reset=1, proc_en=0.
  - start clears error and is evaluated as in IDLE in the same cycle.
- Simultaneous events and edge cases:
  - start outside IDLE/ERROR is ignored.
  - stop during FETCH/SHIFT aborts to IDLE with no snapshot and no done pulse; result is unchanged.
  - stop in IDLE is ignored.
  - word_valid outside a word_ready cycle is not consumed.
  - prog_len=INSTRUCTION_MEM is legal.

Optional Feature:
Macro PROG_LOADER_WATCHDOG_EN.
- With it defined:
  - A 16-bit run_cnt clears on entering RUN and increments each RUN cycle.
  - When run_cnt reaches RUN_LIMIT-1, the block enters STOP as if stop were asserted.
  - An extra output port `timeout` (1 bit, reset 0) is set in STOP when the watchdog fired, including when stop arrives in the same cycle. It is cleared on the next accepted start.
- Without it: no counter and no `timeout` port; RUN lasts until stop.

Test Plan:
1. Reset release, no start -> proc_reset=1, proc_en=0, result=0, error=0 held for 20 cycles.
2. start, prog_len=2, words 13'h1A5 and 13'h0F3 presented always-valid -> proc_en high exactly 26 consecutive cycles. proc_in[0] sequence = bits 0..12 of 0x1A5 then of 0x0F3. running=1 on the following cycle.
3. RUN with run_in=2'b10, core model drives proc_out=7'h55, stop pulse -> proc_in=2'b10 during RUN. result=7'h55 and done=1 for one cycle. proc_reset=1 on the next cycle.
4. prog_len=3, word_valid dropped when the 2nd word is due -> ERROR the next cycle, proc_en=0, error=1. A new start with prog_len=1 clears error and loads normally.
5. start with prog_len=0 and with prog_len=1001 -> error=1, proc_en never asserted.
6. Async reset asserted at cycle 7 of SHIFT -> proc_en=0 and proc_reset=1 immediately. With PROG_LOADER_WATCHDOG_EN and RUN_LIMIT=8, a RUN with no stop -> STOP after 8 RUN cycles, timeout=1, done=1.
